// File: rtl/fp_mul_pkg.sv
// Shared FP32 multiply-path definitions: field widths, FSM states, flag indices, packed result word.
package fp_mul_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;
    localparam int unsigned SIG_W = MAN_W + 1;
    localparam int unsigned PW    = 2 * SIG_W;
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned RES_W = 1 + EXP_W + MAN_W;
    localparam int unsigned FLG_W = 3;

    localparam int unsigned FLG_OVF = 2;
    localparam int unsigned FLG_UNF = 1;
    localparam int unsigned FLG_INX = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp_word_t;

endpackage

// File: rtl/fp_mul_norm_round_if.sv
// Product-in / result-out handshake bundle for the FP32 multiply normalise-round stage.
interface fp_mul_norm_round_if;
    import fp_mul_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [PW-1:0]        prod;
    logic signed [EW-1:0] exp_in;
    logic                 sign_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [RES_W-1:0]     result;
    logic [FLG_W-1:0]     flags;
    logic                 overrun;

    modport master (
        output in_valid, prod, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, result, flags, overrun
    );

    modport slave (
        input  in_valid, prod, exp_in, sign_in, out_ready,
        output in_ready, out_valid, result, flags, overrun
    );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised significand with guard/sticky; carry-out renormalises.
module fp_round_rne #(
    parameter int unsigned MAN_W = fp_mul_pkg::MAN_W,
    parameter int unsigned EXP_W = fp_mul_pkg::EXP_W
) (
    input  logic                   [MAN_W:0]   m,
    input  logic                               g,
    input  logic                               s,
    input  logic signed            [EXP_W+1:0] e,
    output logic                   [MAN_W-1:0] frac_c,
    output logic signed            [EXP_W+1:0] e_c,
    output logic                               inexact_c
);

    logic             up;
    logic [MAN_W+1:0] sum;

    always_comb begin
        up        = g & (s | m[0]);
        sum       = {1'b0, m} + (MAN_W+2)'(up);
        frac_c    = sum[MAN_W-1:0];
        e_c       = e;
        inexact_c = g | s;
        // All-ones significand rounded up: result is exactly 1.0 x 2^(e+1)
        if (sum[MAN_W+1]) begin
            frac_c = sum[MAN_W:1];
            e_c    = e + (EXP_W+2)'(1);
        end
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// FP32 multiply back end: normalise 48-bit product, RNE round, range check, pack; 3-cycle valid/ready pipe.
module fp_mul_norm_round
    import fp_mul_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    fp_mul_norm_round_if.slave  bus
);

    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    state_e               state;
    logic [PW-1:0]        prod_q;
    logic signed [EW-1:0] exp_q;
    logic                 sign_q;
    logic [SIG_W-1:0]     m_q;
    logic                 g_q;
    logic                 s_q;
    logic                 zero_q;
    logic signed [EW-1:0] e_q;

    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [RES_W-1:0]     result_q;
    logic [FLG_W-1:0]     flags_q;
    logic                 overrun_q;

    logic [SIG_W-1:0]     m_c;
    logic                 g_c;
    logic                 s_c;
    logic                 zero_c;
    logic signed [EW-1:0] e_c;

    logic [MAN_W-1:0]     frac_rnd_c;
    logic signed [EW-1:0] e_rnd_c;
    logic                 inexact_c;

    fp_word_t             res_c;
    logic [FLG_W-1:0]     flg_c;

    // Normalise: product of two [1,2) significands lies in [1,4)
    always_comb begin
        m_c    = prod_q[PW-2 -: SIG_W];
        g_c    = prod_q[PW-SIG_W-2];
        s_c    = |prod_q[PW-SIG_W-3:0];
        e_c    = exp_q;
        zero_c = ~|prod_q[PW-1 -: 2];
        if (prod_q[PW-1]) begin
            m_c = prod_q[PW-1 -: SIG_W];
            g_c = prod_q[PW-SIG_W-1];
            s_c = |prod_q[PW-SIG_W-2:0];
            e_c = exp_q + EW'(1);
        end
    end

    fp_round_rne #(
        .MAN_W (MAN_W),
        .EXP_W (EXP_W)
    ) u_round (
        .m         (m_q),
        .g         (g_q),
        .s         (s_q),
        .e         (e_q),
        .frac_c    (frac_rnd_c),
        .e_c       (e_rnd_c),
        .inexact_c (inexact_c)
    );

    // Range check and pack; subnormal results flush to signed zero
    always_comb begin
        res_c      = '0;
        res_c.sign = sign_q;
        flg_c      = '0;
        if (zero_q) begin
            res_c.sign = sign_q;
        end else if (e_rnd_c >= E_MAX) begin
            res_c.exp        = '1;
            flg_c[FLG_OVF]   = 1'b1;
            flg_c[FLG_INX]   = 1'b1;
        end else if (e_rnd_c <= E_ZERO) begin
            flg_c[FLG_UNF]   = 1'b1;
            flg_c[FLG_INX]   = 1'b1;
        end else begin
            res_c.exp      = e_rnd_c[EXP_W-1:0];
            res_c.frac     = frac_rnd_c;
            flg_c[FLG_INX] = inexact_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prod_q      <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            m_q         <= '0;
            g_q         <= 1'b0;
            s_q         <= 1'b0;
            zero_q      <= 1'b0;
            e_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= bus.in_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        prod_q     <= bus.prod;
                        exp_q      <= bus.exp_in;
                        sign_q     <= bus.sign_in;
                        in_ready_q <= 1'b0;
                        state      <= NORM;
                    end
                end
                NORM: begin
                    m_q    <= m_c;
                    g_q    <= g_c;
                    s_q    <= s_c;
                    e_q    <= e_c;
                    zero_q <= zero_c;
                    state  <= ROUND;
                end
                ROUND: begin
                    result_q    <= res_c;
                    flags_q     <= flg_c;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed-vector bench for fp_mul_norm_round: arithmetic cases, range limits, handshake and reset.
module tb_fp_mul_norm_round;
    import fp_mul_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fp_mul_norm_round_if bus();

    fp_mul_norm_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operand and wait (bounded) for out_valid; lat = edges from launch to valid
    task automatic run_op(input logic [PW-1:0] p, input logic signed [EW-1:0] e,
                          input logic sg, output int lat);
        bus.prod     = p;
        bus.exp_in   = e;
        bus.sign_in  = sg;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.prod      = '0;
        bus.exp_in    = '0;
        bus.sign_in   = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b overrun=%b, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.overrun);
        end
        n_checks++;
        if (bus.result !== 32'h0 || bus.flags !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_data: result=%h flags=%b, want 00000000 000", bus.result, bus.flags);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat;
        run_op(48'h400000000000, 10'sd127, 1'b0, lat);
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL one_latency: got %0d edges, want 3", lat);
        end
        n_checks++;
        if (bus.result !== 32'h3F800000 || bus.flags !== 3'b000) begin
            n_fail++;
            $display("FAIL one_times_one: result=%h flags=%b, want 3f800000 000", bus.result, bus.flags);
        end
        accept();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_idle: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        run_op(48'h900000000000, 10'sd127, 1'b0, lat);
        n_checks++;
        if (lat !== 3 || bus.result !== 32'h40100000 || bus.flags !== 3'b000) begin
            n_fail++;
            $display("FAIL msb_path: lat=%0d result=%h flags=%b, want 3 40100000 000",
                     lat, bus.result, bus.flags);
        end
        accept();
    endtask

    task automatic test_tie();
        int lat;
        run_op(48'h400000C00000, 10'sd127, 1'b0, lat);
        n_checks++;
        if (bus.result !== 32'h3F800002 || bus.flags !== 3'b001) begin
            n_fail++;
            $display("FAIL tie_round_up: result=%h flags=%b, want 3f800002 001", bus.result, bus.flags);
        end
        accept();
        run_op(48'h400000400000, 10'sd127, 1'b0, lat);
        n_checks++;
        if (bus.result !== 32'h3F800000 || bus.flags !== 3'b001) begin
            n_fail++;
            $display("FAIL tie_even: result=%h flags=%b, want 3f800000 001", bus.result, bus.flags);
        end
        accept();
    endtask

    task automatic test_carry();
        int lat;
        run_op(48'h7FFFFFC00000, 10'sd127, 1'b0, lat);
        n_checks++;
        if (bus.result !== 32'h40000000 || bus.flags !== 3'b001) begin
            n_fail++;
            $display("FAIL round_carry: result=%h flags=%b, want 40000000 001", bus.result, bus.flags);
        end
        accept();
    endtask

    task automatic test_range();
        int lat;
        run_op(48'h400000000000, 10'sd255, 1'b1, lat);
        n_checks++;
        if (bus.result !== 32'hFF800000 || bus.flags !== 3'b101) begin
            n_fail++;
            $display("FAIL overflow: result=%h flags=%b, want ff800000 101", bus.result, bus.flags);
        end
        accept();
        run_op(48'h400000000000, 10'sd0, 1'b0, lat);
        n_checks++;
        if (bus.result !== 32'h00000000 || bus.flags !== 3'b011) begin
            n_fail++;
            $display("FAIL underflow: result=%h flags=%b, want 00000000 011", bus.result, bus.flags);
        end
        accept();
        run_op(48'h000000000000, 10'sd127, 1'b1, lat);
        n_checks++;
        if (bus.result !== 32'h80000000 || bus.flags !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_prod: result=%h flags=%b, want 80000000 000", bus.result, bus.flags);
        end
        accept();
    endtask

    task automatic test_stall();
        int lat;
        run_op(48'h400000C00000, 10'sd127, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.result !== 32'h3F800002 || bus.flags !== 3'b001) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b result=%h flags=%b, want 1 0 3f800002 001",
                         i, bus.out_valid, bus.in_ready, bus.result, bus.flags);
            end
        end
        accept();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_overrun();
        bus.prod     = 48'h900000000000;
        bus.exp_in   = 10'sd127;
        bus.sign_in  = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL norm_busy: in_ready=%b overrun=%b, want 0 0", bus.in_ready, bus.overrun);
        end
        step();
        bus.prod     = 48'h400000000000;
        bus.exp_in   = 10'sd0;
        bus.sign_in  = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_pulse: overrun=%b, want 1", bus.overrun);
        end
        step();
        n_checks++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: overrun=%b, want 0", bus.overrun);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'h40100000 || bus.flags !== 3'b000) begin
            n_fail++;
            $display("FAIL overrun_result: out_valid=%b result=%h flags=%b, want 1 40100000 000",
                     bus.out_valid, bus.result, bus.flags);
        end
        accept();
    endtask

    task automatic test_reset_midop();
        int lat;
        bus.prod     = 48'h900000000000;
        bus.exp_in   = 10'sd127;
        bus.sign_in  = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.overrun !== 1'b0 ||
            bus.result !== 32'h0 || bus.flags !== 3'b000) begin
            n_fail++;
            $display("FAIL midop_reset: in_ready=%b out_valid=%b overrun=%b result=%h flags=%b, want 1 0 0 00000000 000",
                     bus.in_ready, bus.out_valid, bus.overrun, bus.result, bus.flags);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_discard: out_valid=%b, want 0", bus.out_valid);
        end
        rst_n = 1'b1;
        step();
        run_op(48'h400000C00000, 10'sd127, 1'b1, lat);
        n_checks++;
        if (lat !== 3 || bus.result !== 32'hBF800002 || bus.flags !== 3'b001) begin
            n_fail++;
            $display("FAIL post_reset_op: lat=%0d result=%h flags=%b, want 3 bf800002 001",
                     lat, bus.result, bus.flags);
        end
        accept();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_tie();
        test_carry();
        test_range();
        test_stall();
        test_overrun();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
